channel_arbiter: RTL
====================

CHANNEL_ARBITER -- requirements
Module: channel_arbiter

Interface
REQ-001 Parameter WIDTH, default 8, data bits per beat (1..32).
REQ-002 Parameter CHANNELS, default 4, number of input channels (2..8).
REQ-003 Parameter MODE, default 0, arbitration: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-004 Derived constant IDW = max(1, clog2(CHANNELS)), width of channel id.
REQ-005 clock  input  1  sole clock; all state on rising edge.
REQ-006 resetn  input  1  reset is synchronous and active-low.
REQ-007 idata  input  CHANNELS*WIDTH  packed input beats, channel i at bits [i*WIDTH +: WIDTH].
REQ-008 ivalid  input  CHANNELS  per-channel beat valid.
REQ-009 iready  output  CHANNELS  per-channel accept; one-hot or zero.
REQ-010 odata  output  WIDTH  merged output beat.
REQ-011 oid  output  IDW  source channel of odata.
REQ-012 ovalid  output  1  output beat valid.
REQ-013 oready  input  1  downstream accept.
REQ-014 count  output  16  number of completed output transfers, wrapping.

Function
REQ-015 Transfer on any channel (input or output) occurs exactly when valid and ready are both high at a rising clock edge.
REQ-016 Output stage holds one beat (odata, oid, ovalid registered); it can accept when ovalid is low or oready is high.
REQ-017 Grant computed combinationally from ivalid and arbitration state; iready[g] = 1 only for granted channel g and only when output stage can accept; all other iready bits 0.
REQ-018 No grant when no ivalid bit is set; iready = 0.
REQ-019 iready never depends on ivalid of the same channel beyond grant selection; ivalid may not depend on iready (no combinational loop allowed).
REQ-020 Latency: beat accepted at edge N appears with ovalid = 1 after edge N; sustained one beat per cycle when oready stays high.
REQ-021 Round-robin: pointer holds last granted index; grant = first set ivalid bit searching cyclically from pointer+1, wrapping CHANNELS-1 -> 0.
REQ-022 Pointer updates to granted index only on an input transfer; stall (output full, oready low) leaves pointer and grant unchanged.
REQ-023 Fixed priority (MODE=1): grant = lowest set ivalid index; pointer unused.
REQ-024 Simultaneous output drain and input accept in same cycle: new beat replaces old, ovalid stays 1, no bubble.
REQ-025 While ovalid = 1 and oready = 0: odata, oid, ovalid held stable.
REQ-026 count increments by 1 on each output transfer; 16'hFFFF wraps to 0.

Reset
REQ-027 While resetn = 0 at a rising edge: ovalid = 0, odata = 0, oid = 0, count = 0, pointer = CHANNELS-1 (channel 0 first).
REQ-028 Reset mid-operation discards held output beat; iready = 0 during reset cycles.

Structure
REQ-029 Shared package holds MODE encodings (round-robin, fixed) and the IDW width function.
REQ-030 One sub-module, rr_grant: combinational cyclic priority encoder (request vector, pointer, enable in; one-hot grant and index out).

Verification
REQ-031 CHANNELS=4, MODE=0, all ivalid high, oready high, data = channel index -> oid sequence 0,1,2,3,0..., one beat per cycle, first ovalid one cycle after reset release.
REQ-032 Only ivalid[2] high, oready held low 5 cycles -> one beat accepted, ovalid held, iready = 0 for 5 cycles, odata/oid stable (oid=2).
REQ-033 MODE=1, ivalid = 4'b1010 continuously, oready high -> oid always 1; channel 3 never granted.
REQ-034 MODE=0, grant on channel 3 then ivalid = 4'b1001 -> next grant 0 (wrap-around), then 3.
REQ-035 Assert resetn = 0 for one cycle while ovalid = 1 and count = 7 -> next cycle ovalid = 0, count = 0, next grant from channel 0.
REQ-036 Random ivalid/oready 10k cycles against scoreboard -> per-channel order preserved, no loss/duplication, count equals transfers mod 65536.

Source files
------------

// File: rtl/channel_arbiter_pkg.sv
// Shared definitions for the channel arbiter: arbitration mode encodings and
// the channel-id width helper.
package channel_arbiter_pkg;

    localparam int MODE_RR    = 0;
    localparam int MODE_FIXED = 1;

    function automatic int idw_of(input int channels);
        int w;
        w = $clog2(channels);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Cyclic priority encoder: picks the first set request after ptr, wrapping.
// The grant vector is gated by en; idx reflects the winner regardless.
module rr_grant #(
    parameter int CHANNELS = 4,
    parameter int IDW      = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [IDW-1:0]      ptr,
    input  logic                en,
    output logic [CHANNELS-1:0] grant,
    output logic [IDW-1:0]      idx
);

    always_comb begin
        int  c;
        logic found;
        grant = '0;
        idx   = '0;
        c     = 0;
        found = 1'b0;
        for (int k = 1; k <= CHANNELS; k++) begin
            c = (int'(ptr) + k) % CHANNELS;
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = IDW'(c);
                if (en) begin
                    grant[c] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/channel_arbiter.sv
// N-channel valid/ready merger with a one-beat registered output stage and
// either round-robin or fixed (lowest index) arbitration.
module channel_arbiter
    import channel_arbiter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int MODE     = MODE_RR,
    localparam int IDW     = idw_of(CHANNELS)
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic [CHANNELS*WIDTH-1:0] idata,
    input  logic [CHANNELS-1:0]       ivalid,
    output logic [CHANNELS-1:0]       iready,
    output logic [WIDTH-1:0]          odata,
    output logic [IDW-1:0]            oid,
    output logic                      ovalid,
    input  logic                      oready,
    output logic [15:0]               count
);

    localparam logic [IDW-1:0] LAST = IDW'(CHANNELS - 1);

    logic [IDW-1:0]      ptr;
    logic [IDW-1:0]      search_ptr;
    logic [IDW-1:0]      grant_idx;
    logic [CHANNELS-1:0] grant;
    logic                accept;
    logic                take;

    // Reset gating keeps iready low throughout reset cycles.
    assign accept = resetn && (!ovalid || oready);

    // Searching from the last channel makes the encoder return the lowest index.
    assign search_ptr = (MODE == MODE_FIXED) ? LAST : ptr;

    rr_grant #(
        .CHANNELS (CHANNELS),
        .IDW      (IDW)
    ) u_rr_grant (
        .req   (ivalid),
        .ptr   (search_ptr),
        .en    (accept),
        .grant (grant),
        .idx   (grant_idx)
    );

    assign iready = grant;
    assign take   = |grant;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            ovalid <= 1'b0;
            odata  <= '0;
            oid    <= '0;
            count  <= '0;
            ptr    <= LAST;
        end else begin
            if (ovalid && oready) begin
                count <= count + 16'd1;
            end
            if (take) begin
                ovalid <= 1'b1;
                odata  <= idata[int'(grant_idx)*WIDTH +: WIDTH];
                oid    <= grant_idx;
                if (MODE != MODE_FIXED) begin
                    ptr <= grant_idx;
                end
            end else if (oready) begin
                ovalid <= 1'b0;
            end
        end
    end

endmodule
